// File: rtl/uart_pkg.sv
// Shared constants for the UART command dispatcher: default byte width,
// drop reason codes and dispatcher FSM state encodings.
package uart_pkg;

    localparam int unsigned DEF_BYTE_SIZE = 8;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_OVF  = 2'd1;
    localparam logic [1:0] ERR_BAD  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

endpackage

// File: rtl/uart_frame_fifo.sv
// Generic synchronous FIFO, power-of-two depth, head word visible on rdata
// whenever the FIFO is non-empty. Pushes while full and pops while empty are ignored.
module uart_frame_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers are AW bits wide so they wrap modulo DEPTH for free.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_cmd_dispatcher.sv
// Buffers CRC-checked frames from the UART receiver and offers each one to the
// consumer selected by its opcode, dropping and counting malformed, overflowing or stale frames.
module uart_rx_cmd_dispatcher
    import uart_pkg::*;
#(
    parameter int unsigned BYTE_SIZE   = DEF_BYTE_SIZE,
    parameter int unsigned DATA_SIZE   = 64,
    parameter int unsigned NUM_DEST    = 4,
    parameter int unsigned FIFO_DEPTH  = 2,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    input  logic [BYTE_SIZE-1:0] in_opt,
    input  logic [BYTE_SIZE-1:0] in_len,
    input  logic [DATA_SIZE-1:0] in_data,
    output logic [NUM_DEST-1:0]  dst_valid,
    input  logic [NUM_DEST-1:0]  dst_ready,
    output logic [BYTE_SIZE-1:0] dst_opt,
    output logic [BYTE_SIZE-1:0] dst_len,
    output logic [DATA_SIZE-1:0] dst_data,
    output logic                 err_pulse,
    output logic [1:0]           err_code,
    output logic [7:0]           drop_cnt,
    output logic                 busy
);

    localparam int unsigned MAX_BYTES = DATA_SIZE / BYTE_SIZE;
    localparam int unsigned DW        = $clog2(NUM_DEST);
    localparam int unsigned DP        = 1 << DW;
    localparam int unsigned FW        = 2 * BYTE_SIZE + DATA_SIZE;
    localparam int unsigned TW        = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam bit          TMO_EN    = (TIMEOUT_CYC != 0);

    localparam logic [BYTE_SIZE-1:0] MAX_LEN   = BYTE_SIZE'(MAX_BYTES);
    localparam logic [TW-1:0]        TMO_LAST  = TW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
    // Bit i set when index i names a real consumer (matters for non power-of-two NUM_DEST).
    localparam logic [DP-1:0]        DEST_MASK = DP'((64'd1 << NUM_DEST) - 64'd1);

    state_e               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [NUM_DEST-1:0]  dst_valid_d;
    logic                 load;

    logic                 push, pop, full, empty;
    logic [FW-1:0]        head;
    logic [BYTE_SIZE-1:0] head_opt, head_len;
    logic [DATA_SIZE-1:0] head_data;
    logic [DW-1:0]        head_idx;
    logic                 head_ok;

    logic                 hs, tmo, bad, ovf, drop_bt;
    logic [1:0]           n_drop;
    logic [8:0]           drop_sum;

    assign push = in_valid & ~full;
    assign pop  = (state_q == ST_IDLE) & ~empty;

    uart_frame_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push),
        .wdata ({in_opt, in_len, in_data}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign head_opt  = head[FW-1 -: BYTE_SIZE];
    assign head_len  = head[DATA_SIZE +: BYTE_SIZE];
    assign head_data = head[DATA_SIZE-1:0];
    assign head_idx  = head_opt[DW-1:0];
    assign head_ok   = (head_len != '0) && (head_len <= MAX_LEN) &&
                       ((head_opt >> DW) == '0) && DEST_MASK[head_idx];

    assign hs      = |(dst_valid & dst_ready);
    assign tmo     = TMO_EN && (state_q == ST_SEND) && !hs && (timer_q == TMO_LAST);
    assign bad     = pop & ~head_ok;
    assign ovf     = in_valid & full;
    assign drop_bt = bad | tmo;

    assign busy = ~empty | (state_q == ST_SEND);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (pop && head_ok) state_d = ST_SEND;
            ST_SEND: if (hs || tmo)      state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        dst_valid_d = dst_valid;
        timer_d     = timer_q;
        load        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                dst_valid_d = '0;
                if (pop && head_ok) begin
                    dst_valid_d = NUM_DEST'(1) << head_idx;
                    timer_d     = '0;
                    load        = 1'b1;
                end
            end
            ST_SEND: begin
                timer_d = timer_q + 1'b1;
                if (hs || tmo) begin
                    dst_valid_d = '0;
                end
            end
            default: dst_valid_d = '0;
        endcase
    end

    // An overflow and a bad/timeout drop can coincide: overflow is reported, both are counted.
    always_comb begin
        n_drop   = {1'b0, ovf} + {1'b0, drop_bt};
        drop_sum = {1'b0, drop_cnt} + {7'b0, n_drop};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            timer_q   <= '0;
            dst_valid <= '0;
            dst_opt   <= '0;
            dst_len   <= '0;
            dst_data  <= '0;
            err_pulse <= 1'b0;
            err_code  <= ERR_NONE;
            drop_cnt  <= '0;
        end else begin
            timer_q   <= timer_d;
            dst_valid <= dst_valid_d;
            if (load) begin
                dst_opt  <= head_opt;
                dst_len  <= head_len;
                dst_data <= head_data;
            end
            err_pulse <= ovf | drop_bt;
            err_code  <= ovf ? ERR_OVF : bad ? ERR_BAD : tmo ? ERR_TMO : ERR_NONE;
            drop_cnt  <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

endmodule
